// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM port between instruction fetch and
// the memory stage. Each request is serialised into little-endian byte
// accesses, and the result is returned with a one-cycle done pulse.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter bit          PRIO_MEM   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_flush,
  output logic                  if_done,
  output logic [31:0]           if_inst,
  input  logic                  mem_req,
  input  logic                  mem_wr,
  input  logic [1:0]            mem_size,
  input  logic                  mem_signed,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_wdata,
  output logic                  mem_done,
  output logic [31:0]           mem_rdata,
  output logic                  if_stall_req,
  output logic                  mem_stall_req,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_wr,
  output logic [7:0]            ram_dout,
  input  logic [7:0]            ram_din
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t                state;
  logic [2:0]            cnt;
  logic [2:0]            nbytes;
  logic                  owner_if;
  logic                  sgn_q;
  logic [1:0]            size_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [31:0]           wdata_q;
  logic [23:0]           rbuf;

  logic                  if_go;
  logic                  grant_mem;
  logic                  grant_if;
  logic [1:0]            g_size;
  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic [7:0]            nxt_wbyte;
  logic [31:0]           rd_word;

  function automatic logic [2:0] size_bytes(input logic [1:0] s);
    case (s)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  assign if_stall_req  = if_req & ~if_done;
  assign mem_stall_req = mem_req & ~mem_done;

  // Grant selection, next byte address/data and final load-word assembly.
  // The last byte of a read is taken straight from ram_din so the result is
  // registered on the same edge that captures it.
  always_comb begin
    if_go     = if_req & ~if_flush;
    grant_mem = mem_req & (PRIO_MEM | ~if_go);
    grant_if  = if_go & ~grant_mem;
    g_size    = grant_mem ? mem_size : 2'b10;
    nxt_addr  = base_q + ADDR_WIDTH'(cnt + 3'd1);
    nxt_wbyte = 8'(wdata_q >> {cnt + 3'd1, 3'b000});
    case (size_q)
      2'b00:   rd_word = {{24{sgn_q & ram_din[7]}}, ram_din};
      2'b01:   rd_word = {{16{sgn_q & ram_din[7]}}, ram_din, rbuf[7:0]};
      default: rd_word = {ram_din, rbuf};
    endcase
  end

  // Arbitration, byte sequencing and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      nbytes    <= '0;
      owner_if  <= 1'b0;
      sgn_q     <= 1'b0;
      size_q    <= '0;
      base_q    <= '0;
      wdata_q   <= '0;
      rbuf      <= '0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
      if_inst   <= '0;
      mem_rdata <= '0;
      ram_addr  <= '0;
      ram_wr    <= 1'b0;
      ram_dout  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_mem || grant_if) begin
            owner_if <= grant_if;
            size_q   <= g_size;
            nbytes   <= size_bytes(g_size);
            sgn_q    <= grant_mem & mem_signed;
            base_q   <= grant_mem ? mem_addr : if_addr;
            ram_addr <= grant_mem ? mem_addr : if_addr;
            wdata_q  <= mem_wdata;
            cnt      <= '0;
            if (grant_mem && mem_wr) begin
              ram_wr   <= 1'b1;
              ram_dout <= mem_wdata[7:0];
              state    <= WR;
            end else begin
              ram_wr   <= 1'b0;
              state    <= RD;
            end
          end
        end
        RD: begin
          if (owner_if && if_flush) begin
            state <= IDLE;
          end else if (cnt == nbytes) begin
            state <= DONE;
            if (owner_if) begin
              if_inst <= rd_word;
              if_done <= 1'b1;
            end else begin
              mem_rdata <= rd_word;
              mem_done  <= 1'b1;
            end
          end else begin
            case (cnt)
              3'd1:    rbuf[7:0]   <= ram_din;
              3'd2:    rbuf[15:8]  <= ram_din;
              3'd3:    rbuf[23:16] <= ram_din;
              default: ;
            endcase
            if (cnt + 3'd1 < nbytes) ram_addr <= nxt_addr;
            cnt <= cnt + 3'd1;
          end
        end
        WR: begin
          if (cnt + 3'd1 == nbytes) begin
            ram_wr   <= 1'b0;
            mem_done <= 1'b1;
            state    <= DONE;
          end else begin
            ram_addr <= nxt_addr;
            ram_dout <= nxt_wbyte;
            cnt      <= cnt + 3'd1;
          end
        end
        DONE: begin
          if_done  <= 1'b0;
          mem_done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: byte RAM model plus a reference model that
// computes load results and byte writes directly from address arithmetic.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, if_done;
  logic [31:0] if_addr, if_inst;
  logic        mem_req, mem_wr, mem_signed, mem_done;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        if_stall_req, mem_stall_req;
  logic [31:0] ram_addr;
  logic        ram_wr;
  logic [7:0]  ram_dout, ram_din;

  int compared = 0;
  int mismatched = 0;

  mem_arbiter #(.ADDR_WIDTH(32), .PRIO_MEM(1'b1)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_inst(if_inst),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_signed(mem_signed), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .if_stall_req(if_stall_req), .mem_stall_req(mem_stall_req),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout),
    .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  // 64 KiB RAM (address bits above 15 alias), one-cycle read latency.
  logic [7:0]  mem [0:65535];
  bit          mem_init = 1'b0;
  logic        poke_en = 1'b0;
  logic [15:0] poke_a = '0;
  logic [7:0]  poke_d = '0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 8'($urandom);
      mem_init <= 1'b1;
    end else begin
      if (ram_wr) mem[ram_addr[15:0]] <= ram_dout;
      if (poke_en) mem[poke_a] <= poke_d;
    end
    ram_din <= mem[ram_addr[15:0]];
  end

  function automatic int unsigned n_of(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a,
                                           input int unsigned n,
                                           input bit sgn);
    logic [31:0] v;
    logic [31:0] ak;
    v = '0;
    for (int unsigned k = 0; k < n; k++) begin
      ak = a + k;
      v  = v | (32'(mem[ak[15:0]]) << (8 * k));
    end
    if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_a = a; poke_d = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic run_if(input logic [31:0] a, output int cyc,
                        output logic [31:0] inst, output bit stall_ok);
    @(negedge clk);
    if_req = 1'b1; if_addr = a;
    cyc = -1; inst = '0; stall_ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) if_addr = $urandom;
      if (if_done) begin cyc = c; inst = if_inst; break; end
      if (!if_stall_req) stall_ok = 1'b0;
    end
    if_req = 1'b0;
  endtask

  task automatic run_mem(input logic wr, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int cyc, output logic [31:0] rd,
                         output bit stall_ok);
    @(negedge clk);
    mem_req = 1'b1; mem_wr = wr; mem_size = sz; mem_signed = sgn;
    mem_addr = a; mem_wdata = wd;
    cyc = -1; rd = '0; stall_ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) begin
        mem_addr = $urandom; mem_wdata = $urandom;
        mem_size = 2'($urandom); mem_signed = 1'($urandom);
        mem_wr = 1'($urandom);
      end
      if (mem_done) begin cyc = c; rd = mem_rdata; break; end
      if (!mem_stall_req) stall_ok = 1'b0;
    end
    mem_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if ({if_done, mem_done, if_inst, mem_rdata, ram_addr, ram_wr, ram_dout} !== '0)
      begin mismatched++; $display("FAIL reset_outputs: got %h required 0",
        {if_done, mem_done, if_inst, mem_rdata, ram_addr, ram_wr, ram_dout}); end
    compared++;
    if ({if_stall_req, mem_stall_req} !== 2'b00)
      begin mismatched++; $display("FAIL reset_stall: got %b required 00",
        {if_stall_req, mem_stall_req}); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    int cyc; logic [31:0] inst; bit ok;
    poke(16'h0100, 8'h13); poke(16'h0101, 8'h05);
    poke(16'h0102, 8'hA0); poke(16'h0103, 8'h00);
    run_if(32'h0000_0100, cyc, inst, ok);
    compared++;
    if (cyc !== 5) begin mismatched++;
      $display("FAIL fetch_latency: got %0d required 5", cyc); end
    compared++;
    if (inst !== 32'h00A0_0513) begin mismatched++;
      $display("FAIL fetch_data: got %h required 00a00513", inst); end
    compared++;
    if (ok !== 1'b1) begin mismatched++;
      $display("FAIL fetch_stall: got %0b required 1", ok); end
  endtask

  task automatic test_priority();
    int md, id; logic [31:0] mrd, inst, exp_m, exp_i; bit ok, clash;
    exp_m = ref_load(32'h1000, 4, 1'b0);
    exp_i = ref_load(32'h0200, 4, 1'b0);
    md = -1; id = -1; ok = 1'b1; clash = 1'b0; mrd = '0; inst = '0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h200;
    mem_req = 1'b1; mem_wr = 1'b0; mem_size = 2'b10; mem_signed = 1'b0;
    mem_addr = 32'h1000;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (if_done && mem_done) clash = 1'b1;
      if (mem_done && md < 0) begin md = c; mrd = mem_rdata; mem_req = 1'b0; end
      if (if_done && id < 0) begin id = c; inst = if_inst; if_req = 1'b0; break; end
      if (!if_stall_req) ok = 1'b0;
    end
    if_req = 1'b0; mem_req = 1'b0;
    compared++;
    if (md !== 5) begin mismatched++;
      $display("FAIL prio_mem_cycle: got %0d required 5", md); end
    compared++;
    if (id !== 5 + 2 + 5) begin mismatched++;
      $display("FAIL prio_if_cycle: got %0d required 12", id); end
    compared++;
    if (mrd !== exp_m) begin mismatched++;
      $display("FAIL prio_mem_data: got %h required %h", mrd, exp_m); end
    compared++;
    if (inst !== exp_i) begin mismatched++;
      $display("FAIL prio_if_data: got %h required %h", inst, exp_i); end
    compared++;
    if (ok !== 1'b1) begin mismatched++;
      $display("FAIL prio_if_stall: got %0b required 1", ok); end
    compared++;
    if (clash !== 1'b0) begin mismatched++;
      $display("FAIL done_exclusive: got %0b required 0", clash); end
  endtask

  task automatic test_loads();
    int cyc; logic [31:0] rd, a, exp; logic [1:0] sz; bit sg, ok;
    poke(16'h1003, 8'h80); poke(16'h1010, 8'h34); poke(16'h1011, 8'hF2);
    run_mem(1'b0, 2'b00, 1'b1, 32'h1003, '0, cyc, rd, ok);
    compared++;
    if (rd !== 32'hFFFF_FF80 || cyc !== 2) begin mismatched++;
      $display("FAIL load_sbyte: got %h @%0d required ffffff80 @2", rd, cyc); end
    run_mem(1'b0, 2'b00, 1'b0, 32'h1003, '0, cyc, rd, ok);
    compared++;
    if (rd !== 32'h0000_0080) begin mismatched++;
      $display("FAIL load_ubyte: got %h required 00000080", rd); end
    run_mem(1'b0, 2'b01, 1'b1, 32'h1010, '0, cyc, rd, ok);
    compared++;
    if (rd !== 32'hFFFF_F234 || cyc !== 3) begin mismatched++;
      $display("FAIL load_shalf: got %h @%0d required fffff234 @3", rd, cyc); end
    for (int i = 0; i < 15; i++) begin
      a = $urandom_range(0, 65535);
      if (i % 3 == 0) begin
        exp = ref_load(a, 4, 1'b0);
        run_if(a, cyc, rd, ok);
        compared++;
        if (rd !== exp || cyc !== 5 || !ok) begin mismatched++;
          $display("FAIL rand_fetch[%0d]: got %h @%0d stall_ok=%0b required %h @5",
                   i, rd, cyc, ok, exp); end
      end else begin
        sz = 2'($urandom); sg = 1'($urandom);
        exp = ref_load(a, n_of(sz), sg);
        run_mem(1'b0, sz, sg, a, '0, cyc, rd, ok);
        compared++;
        if (rd !== exp || cyc !== int'(n_of(sz)) + 1 || !ok) begin mismatched++;
          $display("FAIL rand_load[%0d]: got %h @%0d stall_ok=%0b required %h @%0d",
                   i, rd, cyc, ok, exp, n_of(sz) + 1); end
      end
    end
  endtask

  task automatic test_store_wrap();
    int md, nw; bit bad;
    logic [31:0] wa [4];
    logic [7:0]  wb [4];
    wa = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    wb = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    md = -1; nw = 0; bad = 1'b0;
    @(negedge clk);
    mem_req = 1'b1; mem_wr = 1'b1; mem_size = 2'b10; mem_signed = 1'b0;
    mem_addr = 32'hFFFF_FFFE; mem_wdata = 32'hDEAD_BEEF;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (ram_wr) begin
        if (nw >= 4) bad = 1'b1;
        else if (ram_addr !== wa[nw] || ram_dout !== wb[nw] || c != nw) bad = 1'b1;
        nw++;
      end
      if (mem_done) begin md = c; break; end
    end
    mem_req = 1'b0;
    compared++;
    if (bad || nw != 4) begin mismatched++;
      $display("FAIL store_wrap_bytes: got %0d writes bad=%0b required 4 writes in order",
               nw, bad); end
    compared++;
    if (md !== 4) begin mismatched++;
      $display("FAIL store_wrap_done: got %0d required 4", md); end
    compared++;
    if (mem[16'hFFFE] !== 8'hEF || mem[16'h0001] !== 8'hDE) begin mismatched++;
      $display("FAIL store_wrap_ram: got %h %h required ef de",
               mem[16'hFFFE], mem[16'h0001]); end
  endtask

  task automatic test_stores();
    int cyc; logic [31:0] rd, a, wd, ak; logic [1:0] sz; logic [7:0] nxt; bit ok, bad;
    int unsigned n;
    for (int i = 0; i < 8; i++) begin
      a = $urandom_range(0, 65535); wd = $urandom; sz = 2'($urandom);
      n = n_of(sz);
      ak = a + n; nxt = mem[ak[15:0]];
      run_mem(1'b1, sz, 1'b0, a, wd, cyc, rd, ok);
      bad = 1'b0;
      for (int unsigned k = 0; k < n; k++) begin
        ak = a + k;
        if (mem[ak[15:0]] !== 8'(wd >> (8 * k))) bad = 1'b1;
      end
      ak = a + n;
      if (mem[ak[15:0]] !== nxt) bad = 1'b1;
      compared++;
      if (bad || cyc !== int'(n) || !ok) begin mismatched++;
        $display("FAIL rand_store[%0d]: ram_bad=%0b done @%0d stall_ok=%0b required @%0d",
                 i, bad, cyc, ok, n); end
    end
  endtask

  task automatic test_flush();
    int id, cyc; logic [31:0] inst, exp, rd; bit ok;
    poke(16'h0300, 8'h93); poke(16'h0301, 8'h02);
    poke(16'h0302, 8'h10); poke(16'h0303, 8'h7F);
    exp = 32'h7F10_0293;
    id = -1; inst = '0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (if_done) begin id = c; inst = if_inst; break; end
      if (c == 2) if_flush = 1'b1;
      if (c == 3) begin if_flush = 1'b0; if_addr = 32'h300; end
    end
    if_req = 1'b0;
    compared++;
    if (id !== 9 || inst !== exp) begin mismatched++;
      $display("FAIL flush_refetch: got %h @%0d required %h @9", inst, id, exp); end
    id = -1;
    @(negedge clk);
    if_req = 1'b1; if_flush = 1'b1; if_addr = 32'h300;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c == 0) if_flush = 1'b0;
      if (if_done) begin id = c; break; end
    end
    if_req = 1'b0;
    compared++;
    if (id !== 6) begin mismatched++;
      $display("FAIL flush_suppress_grant: got %0d required 6", id); end
    if_flush = 1'b1;
    exp = ref_load(32'h1010, 4, 1'b0);
    run_mem(1'b0, 2'b10, 1'b0, 32'h1010, '0, cyc, rd, ok);
    if_flush = 1'b0;
    compared++;
    if (rd !== exp || cyc !== 5) begin mismatched++;
      $display("FAIL flush_ignored_by_mem: got %h @%0d required %h @5", rd, cyc, exp); end
  endtask

  task automatic test_reset_mid_store();
    int md; bit saw_done, bad; logic [31:0] ak;
    poke(16'h2000, 8'h00); poke(16'h2001, 8'h00);
    poke(16'h2002, 8'h00); poke(16'h2003, 8'h00);
    saw_done = 1'b0; md = -1;
    @(negedge clk);
    mem_req = 1'b1; mem_wr = 1'b1; mem_size = 2'b10; mem_signed = 1'b0;
    mem_addr = 32'h2000; mem_wdata = 32'hCAFE_F00D;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mem_done) saw_done = 1'b1;
    end
    #1 rst = 1'b0;
    #1;
    compared++;
    if ({if_done, mem_done, if_inst, mem_rdata, ram_addr, ram_wr, ram_dout} !== '0)
      begin mismatched++; $display("FAIL async_reset_outputs: got %h required 0",
        {if_done, mem_done, if_inst, mem_rdata, ram_addr, ram_wr, ram_dout}); end
    compared++;
    if (mem[16'h2001] !== 8'hF0 || mem[16'h2002] !== 8'h00) begin mismatched++;
      $display("FAIL reset_partial_store: got %h %h required f0 00",
               mem[16'h2001], mem[16'h2002]); end
    @(negedge clk);
    if (mem_done) saw_done = 1'b1;
    rst = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0 && !(ram_wr === 1'b1 && ram_addr === 32'h2000 && ram_dout === 8'h0D))
        bad = 1'b1;
      if (mem_done) begin md = c; break; end
    end
    mem_req = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      ak = 32'h2000 + k;
      if (mem[ak[15:0]] !== 8'(32'hCAFE_F00D >> (8 * k))) bad = 1'b1;
    end
    compared++;
    if (bad || md !== 4) begin mismatched++;
      $display("FAIL reset_restart_store: bad=%0b done @%0d required restart at byte 0, done @4",
               bad, md); end
    compared++;
    if (saw_done !== 1'b0) begin mismatched++;
      $display("FAIL reset_no_done: got %0b required 0", saw_done); end
  endtask

  initial begin
    rst = 1'b0;
    if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_wr = 1'b0; mem_size = '0; mem_signed = 1'b0;
    mem_addr = '0; mem_wdata = '0;
    test_reset();
    test_fetch();
    test_priority();
    test_loads();
    test_store_wrap();
    test_stores();
    test_flush();
    test_reset_mid_store();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single byte-wide RAM port between instruction fetch (IF, 32-bit reads only) and the memory stage (MEM, byte/half/word loads and stores).
- Serialises each request into byte accesses, little-endian.
- Returns assembled data with a one-cycle done pulse.
- Drives stall requests to ctrl so IF/ID/ID_EX hold or bubble while an access is in flight.

Parameters:
- ADDR_WIDTH, 32, width of all byte addresses.
- PRIO_MEM, 1, 1 = MEM wins simultaneous requests; 0 = IF wins.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_done
- if_addr  in  ADDR_WIDTH  fetch address
- if_flush  in  1  abort in-flight fetch (branch taken / idex_clear)
- if_done  out  1  one-cycle pulse; if_inst valid
- if_inst  out  32  fetched instruction
- mem_req  in  1  load/store request; held until mem_done
- mem_wr  in  1  1 = store
- mem_size  in  2  00 byte, 01 half, 10/11 word
- mem_signed  in  1  sign-extend load result
- mem_addr  in  ADDR_WIDTH  byte address
- mem_wdata  in  32  store data
- mem_done  out  1  one-cycle pulse; load data valid / store complete
- mem_rdata  out  32  extended load result
- if_stall_req  out  1  = if_req & ~if_done
- mem_stall_req  out  1  = mem_req & ~mem_done
- ram_addr  out  ADDR_WIDTH  RAM byte address
- ram_wr  out  1  RAM write strobe
- ram_dout  out  8  RAM write byte
- ram_din  in  8  RAM read byte; valid one cycle after its address

Behaviour:
- Reset (rst=0, async): state IDLE. All registered outputs are 0: if_done, mem_done, if_inst, mem_rdata, ram_addr, ram_wr, ram_dout.
- Reset mid-transaction discards all progress. No done pulse is generated.
- States:
  - IDLE
  - RD: issue byte k while capturing byte k-1.
  - WR: issue byte k.
  - DONE: one cycle; done pulse asserted, RAM idle.
- Arbitration occurs only in IDLE.
  - With both requests and PRIO_MEM=1, MEM is granted. The loser waits and keeps its stall request high.
  - A grant latches address, size, wr, signed and wdata. Later changes to the inputs are ignored until DONE.
  - Requests are not considered on the cycle a done pulse is asserted. Re-arbitration happens from IDLE the next cycle.
- Byte count N: 1, 2 or 4 (IF always 4).
- Read timing:
  - Cycles 0..N-1 drive ram_addr = base+k, ram_wr=0.
  - ram_din captured at cycles 1..N into byte lane k.
  - DONE is reached after cycle N, so done pulses at cycle N+1 from grant. Word load = 6 cycles, grant cycle is cycle 0.
- Write timing:
  - Cycles 0..N-1 drive ram_addr = base+k, ram_wr=1, ram_dout = wdata byte k.
  - DONE is at cycle N. Word store = 5 cycles.
  - ram_wr=0 in every other state.
- Address arithmetic: base+k wraps modulo 2^ADDR_WIDTH. Misaligned addresses are legal; no trap.
- Load extension:
  - byte: bit 7 replicated if mem_signed, else zeros.
  - half: bit 15 replicated if mem_signed, else zeros.
  - word: no extension.
- if_flush during an IF read:
  - Current byte finishes its cycle, then the state returns to IDLE with no if_done.
  - if_flush in the same cycle IF would be granted suppresses that grant.
  - if_flush has no effect on MEM transactions.
- if_inst/mem_rdata hold their last value between done pulses.
- if_done and mem_done are never high in the same cycle.
- Stores never abort once granted.

Test Plan:
- Reset then word fetch at 0x0000_0100, RAM bytes 13,05,A0,00 -> if_done at cycle 5 after grant, if_inst=0x00A0_0513; if_stall_req high cycles 0..4.
- Simultaneous if_req (0x200) and mem_req load-word (0x1000) with PRIO_MEM=1 -> mem_done first; IF is then granted from IDLE the cycle after mem_done; if_stall_req stays high throughout.
- Signed byte load at 0x1003, RAM byte 0x80 -> mem_rdata=0xFFFF_FF80; same access with mem_signed=0 -> 0x0000_0080; half load of bytes 34,F2 signed -> 0xFFFF_F234.
- Store word 0xDEAD_BEEF to 0xFFFF_FFFE -> ram_wr high 4 cycles, addresses FFFF_FFFE, FFFF_FFFF, 0000_0000, 0000_0001 with bytes EF, BE, AD, DE; mem_done at cycle 4.
- IF fetch with if_flush pulsed at cycle 2 -> no if_done, state IDLE by cycle 3, new fetch at 0x300 then completes normally.
- rst low at cycle 2 of a store -> all outputs 0 immediately (asynchronous), no mem_done; after release, the held mem_req restarts from byte 0.
